// File: rtl/pipeline_controller_if.sv
// Control/status bundle between the RSA ASIP datapath and its pipeline controller.
// The master side is the controller; the slave side is the datapath.
interface pipeline_controller_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    // ID-stage decode fields
    logic [2:0]       id_opcode;
    logic [1:0]       id_funct;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    // EX / MEM status
    logic             ex_is_load;
    logic [REG_W-1:0] ex_rd;
    logic [1:0]       ex_branch;
    logic             ex_zero;
    logic             mem_access;
    logic             mem_ready;
    // Pipeline control
    logic             pc_en;
    logic             pc_src;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             mem_wb_bubble;
    // Memory handshake: mem_req stays high until the cycle in which mem_ready is seen;
    // that cycle completes the access and the pipeline advances.
    logic             mem_req;
    logic             err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  id_opcode, id_funct, id_rs1, id_rs2,
        input  ex_is_load, ex_rd, ex_branch, ex_zero,
        input  mem_access, mem_ready,
        output pc_en, pc_src, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        output ex_mem_en, mem_wb_bubble, mem_req, err, stall_cnt
    );

    modport slave (
        output id_opcode, id_funct, id_rs1, id_rs2,
        output ex_is_load, ex_rd, ex_branch, ex_zero,
        output mem_access, mem_ready,
        input  pc_en, pc_src, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        input  ex_mem_en, mem_wb_bubble, mem_req, err, stall_cnt
    );
endinterface

// File: rtl/pipeline_controller.sv
// Hazard and sequencing controller for the 5-stage RSA ASIP: load-use stalls,
// taken-branch squashes, multi-cycle data-memory waits and a sticky timeout error.
module pipeline_controller #(
    parameter int REG_W       = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_controller_if.master  bus,
    output logic [1:0]             state_o
);

    localparam logic [1:0] ST_INIT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_ERROR    = 2'd3;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] BR_JEQ = 2'b00;
    localparam logic [1:0] BR_JNE = 2'b01;
    localparam logic [1:0] BR_JMP = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              err_q, err_d;

    logic rs1_used;
    logic rs2_used;
    logic load_use;
    logic br_taken;
    logic mem_stall;

    logic pc_en;
    logic pc_src;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_bubble;
    logic mem_req;

    // Source-operand usage by the ID-stage instruction
    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (bus.id_opcode)
            3'b000: begin
                rs1_used = 1'b1;
                rs2_used = ~bus.id_funct[0];
            end
            3'b001: begin
                rs1_used = 1'b1;
                rs2_used = (bus.id_funct == 2'b10);
            end
            3'b010: begin
                rs1_used = 1'b1;
            end
            3'b011: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            default: begin
                rs1_used = 1'b0;
                rs2_used = 1'b0;
            end
        endcase
    end

    always_comb begin
        load_use = bus.ex_is_load &&
                   ((rs1_used && (bus.id_rs1 == bus.ex_rd)) ||
                    (rs2_used && (bus.id_rs2 == bus.ex_rd)));
        br_taken = ((bus.ex_branch == BR_JEQ) &&  bus.ex_zero) ||
                   ((bus.ex_branch == BR_JNE) && !bus.ex_zero) ||
                    (bus.ex_branch == BR_JMP);
        mem_stall = bus.mem_access && !bus.mem_ready;
    end

    // Defaults are the frozen/flushed pattern shared by INIT and reset.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        pc_en         = 1'b0;
        pc_src        = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b1;
        id_ex_en      = 1'b0;
        id_ex_flush   = 1'b1;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
        mem_req       = 1'b0;

        case (state_q)
            ST_INIT: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end

            ST_RUN: begin
                pc_en         = 1'b1;
                if_id_en      = 1'b1;
                if_id_flush   = 1'b0;
                id_ex_en      = 1'b1;
                id_ex_flush   = 1'b0;
                ex_mem_en     = 1'b1;
                mem_wb_bubble = 1'b0;
                mem_req       = bus.mem_access;
                wait_d        = '0;
                if (mem_stall) begin
                    // This RUN cycle is already the first cycle of the wait.
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_en     = 1'b0;
                    mem_wb_bubble = 1'b1;
                    wait_d        = WAIT_W'(1);
                    state_d       = ST_MEM_WAIT;
                end else if (br_taken) begin
                    pc_src      = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                if_id_flush = 1'b0;
                id_ex_flush = 1'b0;
                mem_req     = bus.mem_access;
                if (bus.mem_ready) begin
                    // Branches seen while waiting are left for RUN to re-evaluate.
                    pc_en         = 1'b1;
                    if_id_en      = 1'b1;
                    id_ex_en      = 1'b1;
                    ex_mem_en     = 1'b1;
                    mem_wb_bubble = 1'b0;
                    wait_d        = '0;
                    state_d       = ST_RUN;
                end else if (wait_q >= WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = ST_ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_ERROR: begin
                if_id_flush = 1'b0;
                id_ex_flush = 1'b0;
                wait_d      = '0;
                state_d     = ST_ERROR;
            end

            default: begin
                state_d = ST_INIT;
                wait_d  = '0;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !pc_en &&
            (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
        err_d = err_q || (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            wait_q  <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign bus.pc_en         = pc_en;
    assign bus.pc_src        = pc_src;
    assign bus.if_id_en      = if_id_en;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.id_ex_en      = id_ex_en;
    assign bus.id_ex_flush   = id_ex_flush;
    assign bus.ex_mem_en     = ex_mem_en;
    assign bus.mem_wb_bubble = mem_wb_bubble;
    assign bus.mem_req       = mem_req;
    assign bus.err           = err_q;
    assign bus.stall_cnt     = stall_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: reset/INIT, load-use, branch flush,
// memory wait with release, timeout error and asynchronous abort.
module tb_pipeline_controller;

    localparam int REG_W       = 4;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 16;

    localparam logic [1:0] ST_INIT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_ERROR    = 2'd3;

    logic       clk;
    logic       rst_n;
    logic [1:0] state;

    int n_vectors;
    int n_miscompares;

    pipeline_controller_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipeline_controller #(
        .REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .state_o(state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver tasks: inputs change just after a negedge, checks follow 1 time unit later.
    task automatic drive_idle();
        bus.id_opcode  = 3'b111;
        bus.id_funct   = 2'b00;
        bus.id_rs1     = '0;
        bus.id_rs2     = '0;
        bus.ex_is_load = 1'b0;
        bus.ex_rd      = '0;
        bus.ex_branch  = 2'b11;
        bus.ex_zero    = 1'b0;
        bus.mem_access = 1'b0;
        bus.mem_ready  = 1'b0;
    endtask

    task automatic drive_id(input logic [2:0] op, input logic [1:0] fn,
                            input logic [3:0] rs1, input logic [3:0] rs2);
        bus.id_opcode = op;
        bus.id_funct  = fn;
        bus.id_rs1    = rs1;
        bus.id_rs2    = rs2;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_run_normal(input string tag);
        check({tag, ".pc_en"},       32'(bus.pc_en), 1);
        check({tag, ".if_id_flush"}, 32'(bus.if_id_flush), 0);
        check({tag, ".id_ex_flush"}, 32'(bus.id_ex_flush), 0);
        check({tag, ".pc_src"},      32'(bus.pc_src), 0);
    endtask

    initial begin
        int waited;
        n_vectors     = 0;
        n_miscompares = 0;
        rst_n = 1'b0;
        drive_idle();
        bus.mem_access = 1'b1;
        settle();

        // Reset pattern, even with a memory access pending
        check("rst.pc_en",         32'(bus.pc_en), 0);
        check("rst.if_id_en",      32'(bus.if_id_en), 0);
        check("rst.ex_mem_en",     32'(bus.ex_mem_en), 0);
        check("rst.pc_src",        32'(bus.pc_src), 0);
        check("rst.if_id_flush",   32'(bus.if_id_flush), 1);
        check("rst.id_ex_flush",   32'(bus.id_ex_flush), 1);
        check("rst.mem_wb_bubble", 32'(bus.mem_wb_bubble), 1);
        check("rst.mem_req",       32'(bus.mem_req), 0);
        check("rst.err",           32'(bus.err), 0);
        check("rst.stall_cnt",     32'(bus.stall_cnt), 0);

        next_cycle();
        rst_n = 1'b1;
        drive_idle();
        settle();
        check("init.state",       32'(state), 32'(ST_INIT));
        check("init.if_id_flush", 32'(bus.if_id_flush), 1);
        check("init.pc_en",       32'(bus.pc_en), 0);

        next_cycle();
        settle();
        check("run.state", 32'(state), 32'(ST_RUN));
        check_run_normal("run");
        check("run.stall_cnt", 32'(bus.stall_cnt), 0);

        // Load-use on rs2 (ADD-type, Funct 00 uses rs2)
        next_cycle();
        bus.ex_is_load = 1'b1;
        bus.ex_rd      = 4'd3;
        drive_id(3'b000, 2'b00, 4'd0, 4'd3);
        settle();
        check("lu_rs2.pc_en",       32'(bus.pc_en), 0);
        check("lu_rs2.if_id_en",    32'(bus.if_id_en), 0);
        check("lu_rs2.id_ex_flush", 32'(bus.id_ex_flush), 1);
        check("lu_rs2.id_ex_en",    32'(bus.id_ex_en), 1);
        check("lu_rs2.ex_mem_en",   32'(bus.ex_mem_en), 1);

        next_cycle();
        drive_idle();
        settle();
        check_run_normal("lu_after");
        check("lu_after.stall_cnt", 32'(bus.stall_cnt), 1);

        // Funct 01 does not read rs2: no stall
        bus.ex_is_load = 1'b1;
        bus.ex_rd      = 4'd3;
        drive_id(3'b000, 2'b01, 4'd5, 4'd3);
        settle();
        check_run_normal("no_lu");

        // LDR reads rs1
        next_cycle();
        drive_id(3'b010, 2'b00, 4'd3, 4'd0);
        settle();
        check("lu_rs1.pc_en",       32'(bus.pc_en), 0);
        check("lu_rs1.id_ex_flush", 32'(bus.id_ex_flush), 1);

        // OpCode 100 uses no register sources
        next_cycle();
        drive_id(3'b100, 2'b00, 4'd3, 4'd3);
        settle();
        check_run_normal("op100");
        check("op100.stall_cnt", 32'(bus.stall_cnt), 2);

        // JNE with zero clear is taken
        next_cycle();
        drive_idle();
        bus.ex_branch = 2'b01;
        bus.ex_zero   = 1'b0;
        settle();
        check("jne.pc_src",      32'(bus.pc_src), 1);
        check("jne.if_id_flush", 32'(bus.if_id_flush), 1);
        check("jne.id_ex_flush", 32'(bus.id_ex_flush), 1);
        check("jne.pc_en",       32'(bus.pc_en), 1);

        // JEQ with zero clear is not taken
        next_cycle();
        bus.ex_branch = 2'b00;
        bus.ex_zero   = 1'b0;
        settle();
        check_run_normal("jeq_nt");

        // JMP beats a simultaneous load-use
        next_cycle();
        bus.ex_branch  = 2'b10;
        bus.ex_is_load = 1'b1;
        bus.ex_rd      = 4'd7;
        drive_id(3'b011, 2'b00, 4'd7, 4'd7);
        settle();
        check("jmp_lu.pc_src", 32'(bus.pc_src), 1);
        check("jmp_lu.pc_en",  32'(bus.pc_en), 1);

        next_cycle();
        drive_idle();
        settle();
        check("jmp_lu.stall_cnt", 32'(bus.stall_cnt), 2);

        // Memory wait: ready low 3 cycles, high on the 4th
        bus.mem_access = 1'b1;
        settle();
        check("mw1.mem_req",   32'(bus.mem_req), 1);
        check("mw1.pc_en",     32'(bus.pc_en), 0);
        check("mw1.ex_mem_en", 32'(bus.ex_mem_en), 0);
        check("mw1.bubble",    32'(bus.mem_wb_bubble), 1);

        next_cycle();
        bus.ex_branch = 2'b10;
        settle();
        check("mw2.state",   32'(state), 32'(ST_MEM_WAIT));
        check("mw2.mem_req", 32'(bus.mem_req), 1);
        check("mw2.pc_src",  32'(bus.pc_src), 0);
        check("mw2.if_id_en", 32'(bus.if_id_en), 0);

        next_cycle();
        settle();
        check("mw3.mem_req", 32'(bus.mem_req), 1);
        check("mw3.pc_en",   32'(bus.pc_en), 0);

        next_cycle();
        bus.mem_ready = 1'b1;
        settle();
        check("mw4.mem_req",   32'(bus.mem_req), 1);
        check("mw4.ex_mem_en", 32'(bus.ex_mem_en), 1);
        check("mw4.bubble",    32'(bus.mem_wb_bubble), 0);
        check("mw4.pc_en",     32'(bus.pc_en), 1);
        check("mw4.pc_src",    32'(bus.pc_src), 0);

        next_cycle();
        drive_idle();
        settle();
        check("mw_after.state", 32'(state), 32'(ST_RUN));
        check("mw_after.stall_cnt", 32'(bus.stall_cnt), 5);
        check("mw_after.mem_req", 32'(bus.mem_req), 0);

        // Timeout: count non-error cycles with the request outstanding
        next_cycle();
        bus.mem_access = 1'b1;
        waited = 0;
        settle();
        for (int i = 0; i < 40; i++) begin
            if (bus.err) break;
            if (bus.mem_req) waited++;
            next_cycle();
            settle();
        end
        check("to.wait_cycles", 32'(waited), 32'(MEM_TIMEOUT));
        check("to.err",       32'(bus.err), 1);
        check("to.state",     32'(state), 32'(ST_ERROR));
        check("to.mem_req",   32'(bus.mem_req), 0);
        check("to.pc_en",     32'(bus.pc_en), 0);
        check("to.ex_mem_en", 32'(bus.ex_mem_en), 0);

        next_cycle();
        next_cycle();
        bus.mem_ready = 1'b1;
        settle();
        check("to_sticky.err",       32'(bus.err), 1);
        check("to_sticky.stall_cnt", 32'(bus.stall_cnt), 5 + MEM_TIMEOUT);

        // Asynchronous reset clears the error at once
        #1;
        rst_n = 1'b0;
        #1;
        check("to_rst.err",       32'(bus.err), 0);
        check("to_rst.stall_cnt", 32'(bus.stall_cnt), 0);
        check("to_rst.state",     32'(state), 32'(ST_INIT));

        // Reset mid-wait drops the request immediately
        next_cycle();
        rst_n = 1'b1;
        drive_idle();
        next_cycle();
        bus.mem_access = 1'b1;
        settle();
        check("abort.mem_req_pre", 32'(bus.mem_req), 1);
        next_cycle();
        settle();
        check("abort.state_pre", 32'(state), 32'(ST_MEM_WAIT));
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.mem_req", 32'(bus.mem_req), 0);
        check("abort.pc_en",   32'(bus.pc_en), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
Sequencing and hazard controller for the pipelined RSA-decryption ASIP core (IF/ID/EX/MEM/WB). It decodes the ID-stage OpCode/Funct, together with the EX/MEM-stage status, and drives the pipeline-register enables, flushes, PC select and the data-memory request handshake. It resolves load-use stalls, taken-branch flushes and multi-cycle memory waits. It also keeps a stall-cycle counter and a sticky memory-timeout error.

Parameters:
REG_W, 4, register-address width
MEM_TIMEOUT, 16, max cycles waiting for mem_ready before error
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_opcode  in  3  OpCode of instruction in ID
id_funct  in  2  Funct of instruction in ID
id_rs1  in  REG_W  ID source register 1
id_rs2  in  REG_W  ID source register 2
ex_is_load  in  1  EX holds LDR (OpCode 010)
ex_rd  in  REG_W  EX destination register
ex_branch  in  2  Branch code in EX: 00 JEQ, 01 JNE, 10 JMP, 11 none
ex_zero  in  1  zero flag valid for EX branch
mem_access  in  1  MEM holds LDR or STR
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC update enable
pc_src  out  1  1 = load branch target
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID clear to NOP (OpCode 111)
id_ex_en  out  1  ID/EX enable
id_ex_flush  out  1  ID/EX bubble insert
ex_mem_en  out  1  EX/MEM enable
mem_wb_bubble  out  1  MEM/WB loads NOP
mem_req  out  1  data memory request
err  out  1  sticky memory timeout
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- FSM states: INIT, RUN, MEM_WAIT, ERROR. Reset → INIT; counters and err = 0.
- Outputs while rst_n = 0: all enables 0, pc_src 0, if_id_flush 1, id_ex_flush 1, mem_wb_bubble 1, mem_req 0, err 0, stall_cnt 0.
- INIT: one cycle with enables 0 and all flushes/bubble 1, then → RUN.
- RUN defaults: all enables 1; flushes, bubble and pc_src 0. Outputs are combinational from state and inputs.
- rs1 is used by OpCode 000, 001, 010 and 011.
- rs2 is used by:
  - 000 with Funct[0] = 0
  - 001 with Funct = 10
  - 011 (store data)
- Branch taken = (ex_branch = 00 & ex_zero) | (ex_branch = 01 & !ex_zero) | (ex_branch = 10).
- Priority within RUN, highest first:
  1. Memory access not ready: mem_access = 1 and mem_ready = 0. Drive mem_req = 1, all enables 0, mem_wb_bubble = 1, and go to MEM_WAIT next cycle.
  2. Taken branch: pc_src = 1, if_id_flush = 1, id_ex_flush = 1. Two wrong-path instructions are squashed, so the penalty is 2 cycles.
  3. Load-use: ex_is_load = 1 and a used ID source equals ex_rd. Drive pc_en = 0, if_id_en = 0, id_ex_flush = 1; this is a 1-cycle stall.
- mem_req = mem_access in RUN and in MEM_WAIT.
- MEM_WAIT: enables 0, mem_wb_bubble 1, wait counter increments each cycle.
  - On mem_ready = 1, release for that cycle only: ex_mem_en = 1, mem_wb_bubble = 0, other enables 1. Then → RUN; any branch or load-use condition is re-evaluated in RUN.
  - If the wait counter reaches MEM_TIMEOUT without mem_ready → ERROR.
- ERROR: err = 1, all enables 0, mem_req 0. Leaves only via reset.
- A branch arriving during MEM_WAIT is held, not acted on, until release.
- stall_cnt increments (saturating at all-ones) on every cycle in which pc_en = 0 in RUN or MEM_WAIT.
- An asynchronous reset mid-wait aborts the access: mem_req drops immediately.

Test Plan:
- Reset release → one INIT cycle with if_id_flush = 1 and pc_en = 0; next cycle RUN with pc_en = 1 and stall_cnt = 0.
- ex_is_load = 1, ex_rd = 3; ID OpCode 000, Funct 00, id_rs2 = 3 → pc_en = 0, if_id_en = 0, id_ex_flush = 1 for exactly one cycle; stall_cnt = 1.
- Same load, but ID OpCode 000, Funct 01 with id_rs2 = 3 and id_rs1 = 5 → no stall, because rs2 is unused.
- ex_branch = 01, ex_zero = 0 → pc_src = 1, if_id_flush = 1, id_ex_flush = 1. With ex_branch = 00 and ex_zero = 0 → no flush.
- mem_access = 1, mem_ready low for 3 cycles then high → mem_req held 4 cycles, all enables 0 for 3 cycles, release on the 4th cycle; stall_cnt += 3.
- mem_ready never asserted → err = 1 after MEM_TIMEOUT = 16 cycles and stays 1. Assert rst_n = 0 → err = 0 immediately.
